// File: rtl/ysyx_22040895_mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the core memory arbiter.
// The arbiter takes the slave view; the surrounding core/memory environment takes the master view.
interface ysyx_22040895_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_rdy_o;
  logic              if_done_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_err_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [1:0]        ls_size_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic              ls_rdy_o;
  logic              ls_done_o;
  logic [DATA_W-1:0] ls_rdata_o;
  logic              ls_err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [1:0]        mem_size_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdy_o, if_done_o, if_rdata_o, if_err_o,
    input  ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
    output ls_rdy_o, ls_done_o, ls_rdata_o, ls_err_o,
    output mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdy_o, if_done_o, if_rdata_o, if_err_o,
    output ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
    input  ls_rdy_o, ls_done_o, ls_rdata_o, ls_err_o,
    input  mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/ysyx_22040895_mem_arbiter.sv
// Shares the single core memory port between instruction fetch and load/store,
// with LS priority, an IF starvation guard, alignment checking and an ack timeout.
module ysyx_22040895_mem_arbiter #(
  parameter int unsigned ADDR_W        = 64,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned MAX_LS_STREAK = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_22040895_mem_arbiter_if.slave bus
);

  localparam int unsigned STREAK_W = $clog2(MAX_LS_STREAK + 1);
  localparam int unsigned TMO_W    = 8;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_e;

  state_e              state;
  logic [STREAK_W-1:0] streak;
  logic [TMO_W-1:0]    tmo_cnt;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [1:0]        mem_size_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              if_done_q, if_err_q, ls_done_q, ls_err_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

  logic grant_if, if_acc, ls_acc, if_mis, ls_mis;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr);
    case (size)
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      2'b11:   misaligned = |addr;
      default: misaligned = 1'b0;
    endcase
  endfunction

  // IF overrides LS priority only when LS is idle or has hogged the port long enough.
  always_comb begin
    grant_if = !bus.ls_req_i || (bus.if_req_i && (streak == STREAK_MAX));
    if_acc   = rst && (state == IDLE) && bus.if_req_i && grant_if;
    ls_acc   = rst && (state == IDLE) && bus.ls_req_i && !grant_if;
    if_mis   = bus.if_addr_i[1:0] != 2'b00;
    ls_mis   = misaligned(bus.ls_size_i, bus.ls_addr_i[2:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      streak      <= '0;
      tmo_cnt     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_done_q   <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_done_q  <= 1'b0;
      ls_err_q   <= 1'b0;
      ls_rdata_q <= '0;
      case (state)
        IDLE: begin
          if (!bus.if_req_i) streak <= '0;
          if (if_acc) begin
            streak      <= '0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= 2'b10;
            mem_addr_q  <= bus.if_addr_i;
            mem_wdata_q <= '0;
            if (if_mis) begin
              if_done_q <= 1'b1;
              if_err_q  <= 1'b1;
            end else begin
              mem_req_q <= 1'b1;
              state     <= BUSY_IF;
            end
          end else if (ls_acc) begin
            if (bus.if_req_i && (streak != STREAK_MAX)) streak <= streak + STREAK_W'(1);
            mem_we_q    <= bus.ls_we_i;
            mem_size_q  <= bus.ls_size_i;
            mem_addr_q  <= bus.ls_addr_i;
            mem_wdata_q <= bus.ls_wdata_i;
            if (ls_mis) begin
              ls_done_q <= 1'b1;
              ls_err_q  <= 1'b1;
            end else begin
              mem_req_q <= 1'b1;
              state     <= BUSY_LS;
            end
          end
        end
        BUSY_IF, BUSY_LS: begin
          // Ack takes precedence over an expiry in the same cycle.
          if (bus.mem_ack_i) begin
            mem_req_q <= 1'b0;
            tmo_cnt   <= '0;
            state     <= IDLE;
            if (state == BUSY_IF) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= bus.mem_rdata_i;
            end else begin
              ls_done_q  <= 1'b1;
              ls_rdata_q <= mem_we_q ? '0 : bus.mem_rdata_i;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req_q <= 1'b0;
            tmo_cnt   <= '0;
            state     <= IDLE;
            if (state == BUSY_IF) begin
              if_done_q <= 1'b1;
              if_err_q  <= 1'b1;
            end else begin
              ls_done_q <= 1'b1;
              ls_err_q  <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_rdy_o    = if_acc;
  assign bus.ls_rdy_o    = ls_acc;
  assign bus.if_done_o   = if_done_q;
  assign bus.if_err_o    = if_err_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.ls_done_o   = ls_done_q;
  assign bus.ls_err_o    = ls_err_q;
  assign bus.ls_rdata_o  = ls_rdata_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_size_o  = mem_size_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_ysyx_22040895_mem_arbiter.sv
// Directed bench for the fetch / load-store memory arbiter.
module tb_ysyx_22040895_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  ysyx_22040895_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  ysyx_22040895_mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MAX_LS_STREAK(4), .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.ls_req_i    = 1'b0;
    bus.ls_we_i     = 1'b0;
    bus.ls_size_i   = 2'b00;
    bus.ls_addr_i   = '0;
    bus.ls_wdata_i  = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h8000_0000;
    #1;
    total++;
    if ({bus.if_rdy_o, bus.ls_rdy_o, bus.mem_req_o, bus.if_done_o, bus.ls_done_o,
         bus.if_err_o, bus.ls_err_o, bus.mem_we_o} !== 8'h00)
      $display("FAIL reset_ctrl: got %b want 00000000",
               {bus.if_rdy_o, bus.ls_rdy_o, bus.mem_req_o, bus.if_done_o, bus.ls_done_o,
                bus.if_err_o, bus.ls_err_o, bus.mem_we_o});
    else passed++;
    total++;
    if ({bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.ls_rdata_o, bus.mem_size_o} !== '0)
      $display("FAIL reset_data: addr %h wdata %h ifr %h lsr %h size %b want all 0",
               bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.ls_rdata_o, bus.mem_size_o);
    else passed++;
    bus.if_req_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_if_only();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h8000_0000;
    #1;
    total++;
    if (bus.if_rdy_o !== 1'b1) $display("FAIL if_only_rdy: got %b want 1", bus.if_rdy_o);
    else passed++;
    step();
    bus.if_req_i = 1'b0;
    total++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_size_o, bus.mem_addr_o} !== {1'b1, 1'b0, 2'b10, 64'h8000_0000})
      $display("FAIL if_only_bus: req %b we %b size %b addr %h want 1 0 10 80000000",
               bus.mem_req_o, bus.mem_we_o, bus.mem_size_o, bus.mem_addr_o);
    else passed++;
    step();
    total++;
    if ({bus.mem_req_o, bus.if_done_o} !== 2'b10)
      $display("FAIL if_only_hold: req %b done %b want 1 0", bus.mem_req_o, bus.if_done_o);
    else passed++;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 64'h0000_0413;
    step();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    total++;
    if ({bus.if_done_o, bus.if_err_o, bus.mem_req_o, bus.ls_done_o} !== 4'b1000 || bus.if_rdata_o !== 64'h413)
      $display("FAIL if_only_done: done %b err %b req %b lsdone %b rdata %h want 1 0 0 0 413",
               bus.if_done_o, bus.if_err_o, bus.mem_req_o, bus.ls_done_o, bus.if_rdata_o);
    else passed++;
    step();
    total++;
    if (bus.if_done_o !== 1'b0 || bus.if_rdata_o !== 64'h0)
      $display("FAIL if_only_pulse: done %b rdata %h want 0 0", bus.if_done_o, bus.if_rdata_o);
    else passed++;
  endtask

  task automatic test_simultaneous();
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 64'h8000_0000;
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'b1;
    bus.ls_size_i  = 2'b11;
    bus.ls_addr_i  = 64'h8000_1008;
    bus.ls_wdata_i = 64'hDEAD_BEEF;
    #1;
    total++;
    if ({bus.ls_rdy_o, bus.if_rdy_o} !== 2'b10)
      $display("FAIL simul_grant: ls_rdy %b if_rdy %b want 1 0", bus.ls_rdy_o, bus.if_rdy_o);
    else passed++;
    step();
    bus.ls_req_i = 1'b0;
    #1;
    total++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_size_o, bus.if_rdy_o} !== 5'b11110 ||
        bus.mem_addr_o !== 64'h8000_1008 || bus.mem_wdata_o !== 64'hDEAD_BEEF)
      $display("FAIL simul_store: req %b we %b size %b ifrdy %b addr %h wdata %h want 1 1 11 0 80001008 deadbeef",
               bus.mem_req_o, bus.mem_we_o, bus.mem_size_o, bus.if_rdy_o, bus.mem_addr_o, bus.mem_wdata_o);
    else passed++;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 64'h1234;
    step();
    bus.mem_ack_i   = 1'b0;
    #1;
    total++;
    if ({bus.ls_done_o, bus.ls_err_o, bus.mem_req_o, bus.if_rdy_o} !== 4'b1001 || bus.ls_rdata_o !== 64'h0)
      $display("FAIL simul_store_done: done %b err %b req %b ifrdy %b rdata %h want 1 0 0 1 0",
               bus.ls_done_o, bus.ls_err_o, bus.mem_req_o, bus.if_rdy_o, bus.ls_rdata_o);
    else passed++;
    step();
    bus.if_req_i = 1'b0;
    total++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_size_o} !== 4'b1010 || bus.mem_addr_o !== 64'h8000_0000)
      $display("FAIL simul_fetch: req %b we %b size %b addr %h want 1 0 10 80000000",
               bus.mem_req_o, bus.mem_we_o, bus.mem_size_o, bus.mem_addr_o);
    else passed++;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 64'h13;
    step();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    total++;
    if (bus.if_done_o !== 1'b1 || bus.if_rdata_o !== 64'h13)
      $display("FAIL simul_fetch_done: done %b rdata %h want 1 13", bus.if_done_o, bus.if_rdata_o);
    else passed++;
    step();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_grant [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    logic [1:0] got;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h8000_0100;
    bus.ls_req_i  = 1'b1;
    bus.ls_we_i   = 1'b0;
    bus.ls_size_i = 2'b11;
    bus.ls_addr_i = 64'h8000_2000;
    #1;
    for (int i = 0; i < 6; i++) begin
      got = {bus.if_rdy_o, bus.ls_rdy_o};
      total++;
      if (got !== exp_grant[i])
        $display("FAIL starve_grant%0d: {if_rdy,ls_rdy} got %b want %b", i, got, exp_grant[i]);
      else passed++;
      step();
      if (got[1]) bus.if_req_i = 1'b0;
      if (i == 5) bus.ls_req_i = 1'b0;
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 64'(i + 100);
      step();
      bus.mem_ack_i   = 1'b0;
    end
    total++;
    if (bus.ls_done_o !== 1'b1 || bus.ls_rdata_o !== 64'd105)
      $display("FAIL starve_last_done: done %b rdata %h want 1 69", bus.ls_done_o, bus.ls_rdata_o);
    else passed++;
    step();
  endtask

  task automatic test_misaligned();
    bus.ls_req_i  = 1'b1;
    bus.ls_we_i   = 1'b0;
    bus.ls_size_i = 2'b10;
    bus.ls_addr_i = 64'h8000_0002;
    #1;
    total++;
    if (bus.ls_rdy_o !== 1'b1) $display("FAIL mis_ls_rdy: got %b want 1", bus.ls_rdy_o);
    else passed++;
    step();
    bus.ls_req_i = 1'b0;
    total++;
    if ({bus.mem_req_o, bus.ls_done_o, bus.ls_err_o} !== 3'b011 || bus.ls_rdata_o !== 64'h0)
      $display("FAIL mis_ls_resp: req %b done %b err %b rdata %h want 0 1 1 0",
               bus.mem_req_o, bus.ls_done_o, bus.ls_err_o, bus.ls_rdata_o);
    else passed++;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h8000_0006;
    step();
    bus.if_req_i = 1'b0;
    total++;
    if ({bus.mem_req_o, bus.if_done_o, bus.if_err_o, bus.ls_done_o} !== 4'b0110)
      $display("FAIL mis_if_resp: req %b done %b err %b lsdone %b want 0 1 1 0",
               bus.mem_req_o, bus.if_done_o, bus.if_err_o, bus.ls_done_o);
    else passed++;
    // Odd-address byte access is legal and goes to memory.
    bus.ls_req_i  = 1'b1;
    bus.ls_size_i = 2'b00;
    bus.ls_addr_i = 64'h8000_0003;
    step();
    bus.ls_req_i = 1'b0;
    total++;
    if ({bus.mem_req_o, bus.ls_done_o, bus.mem_size_o} !== 4'b1000 || bus.mem_addr_o !== 64'h8000_0003)
      $display("FAIL byte_odd_issue: req %b done %b size %b addr %h want 1 0 00 80000003",
               bus.mem_req_o, bus.ls_done_o, bus.mem_size_o, bus.mem_addr_o);
    else passed++;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 64'h7F;
    step();
    bus.mem_ack_i = 1'b1;
    total++;
    if ({bus.ls_done_o, bus.ls_err_o} !== 2'b10 || bus.ls_rdata_o !== 64'h7F)
      $display("FAIL byte_odd_done: done %b err %b rdata %h want 1 0 7f",
               bus.ls_done_o, bus.ls_err_o, bus.ls_rdata_o);
    else passed++;
    step();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    total++;
    if ({bus.mem_req_o, bus.ls_done_o, bus.if_done_o} !== 3'b000)
      $display("FAIL idle_ack_ignored: req %b lsdone %b ifdone %b want 0 0 0",
               bus.mem_req_o, bus.ls_done_o, bus.if_done_o);
    else passed++;
  endtask

  task automatic run_timeout(input logic ack_at_expiry);
    logic req_dropped;
    req_dropped   = 1'b0;
    bus.ls_req_i  = 1'b1;
    bus.ls_we_i   = 1'b0;
    bus.ls_size_i = 2'b11;
    bus.ls_addr_i = 64'h8000_3000;
    step();
    bus.ls_req_i = 1'b0;
    for (int i = 1; i < 255; i++) begin
      if (bus.mem_req_o !== 1'b1 || bus.ls_done_o !== 1'b0) req_dropped = 1'b1;
      step();
    end
    total++;
    if (req_dropped || bus.mem_req_o !== 1'b1 || bus.ls_done_o !== 1'b0)
      $display("FAIL tmo_hold%0d: early drop %b req %b done %b want 0 1 0",
               ack_at_expiry, req_dropped, bus.mem_req_o, bus.ls_done_o);
    else passed++;
    if (ack_at_expiry) begin
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 64'hCAFE;
    end
    step();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    total++;
    if (ack_at_expiry &&
        ({bus.mem_req_o, bus.ls_done_o, bus.ls_err_o} !== 3'b010 || bus.ls_rdata_o !== 64'hCAFE))
      $display("FAIL tmo_ack_wins: req %b done %b err %b rdata %h want 0 1 0 cafe",
               bus.mem_req_o, bus.ls_done_o, bus.ls_err_o, bus.ls_rdata_o);
    else if (!ack_at_expiry &&
        ({bus.mem_req_o, bus.ls_done_o, bus.ls_err_o} !== 3'b011 || bus.ls_rdata_o !== 64'h0))
      $display("FAIL tmo_expire: req %b done %b err %b rdata %h want 0 1 1 0",
               bus.mem_req_o, bus.ls_done_o, bus.ls_err_o, bus.ls_rdata_o);
    else passed++;
    step();
  endtask

  task automatic test_timeout();
    run_timeout(1'b0);
    run_timeout(1'b1);
  endtask

  task automatic test_reset_mid_op();
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'b1;
    bus.ls_size_i  = 2'b11;
    bus.ls_addr_i  = 64'h8000_4000;
    bus.ls_wdata_i = 64'h1111;
    step();
    bus.ls_req_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({bus.mem_req_o, bus.ls_done_o, bus.mem_we_o} !== 3'b000)
      $display("FAIL rst_mid_drop: req %b done %b we %b want 0 0 0",
               bus.mem_req_o, bus.ls_done_o, bus.mem_we_o);
    else passed++;
    step();
    rst = 1'b1;
    step();
    total++;
    if ({bus.mem_req_o, bus.ls_done_o, bus.ls_err_o} !== 3'b000)
      $display("FAIL rst_mid_nodone: req %b done %b err %b want 0 0 0",
               bus.mem_req_o, bus.ls_done_o, bus.ls_err_o);
    else passed++;
    bus.ls_req_i  = 1'b1;
    bus.ls_we_i   = 1'b0;
    bus.ls_size_i = 2'b10;
    bus.ls_addr_i = 64'h8000_0010;
    #1;
    total++;
    if (bus.ls_rdy_o !== 1'b1) $display("FAIL rst_after_rdy: got %b want 1", bus.ls_rdy_o);
    else passed++;
    step();
    bus.ls_req_i    = 1'b0;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 64'h55;
    step();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    total++;
    if ({bus.ls_done_o, bus.ls_err_o} !== 2'b10 || bus.ls_rdata_o !== 64'h55)
      $display("FAIL rst_after_done: done %b err %b rdata %h want 1 0 55",
               bus.ls_done_o, bus.ls_err_o, bus.ls_rdata_o);
    else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_simultaneous();
    test_starvation();
    test_misaligned();
    test_timeout();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_mem_arbiter.md
Name: ysyx_22040895_mem_arbiter

Overview:
- Shares the single core memory port between instruction fetch (IF, read-only) and the load/store path (LS: the memory-access stage's maddr/wmdata/mwe/munit outputs).
- Grants one requester at a time and holds the memory request until the memory acknowledges it.
- Returns read data or completion status to the owning requester.
- Enforces natural alignment and a bounded wait with an error response on timeout.

Parameters:
- ADDR_W, 64, address width (matches RegBus)
- DATA_W, 64, data width (matches RegBus)
- MAX_LS_STREAK, 4, consecutive LS grants allowed while IF is waiting before IF is forced through
- TIMEOUT, 255, cycles to wait for mem_ack_i before aborting; 8-bit counter

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request; held until accepted
- if_addr_i  in  ADDR_W  fetch address; 4-byte access
- if_rdy_o  out  1  fetch request accepted this cycle (combinational)
- if_done_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  DATA_W  fetch data, valid with if_done_o
- if_err_o  out  1  fetch error, valid with if_done_o
- ls_req_i  in  1  load/store request; held until accepted
- ls_we_i  in  1  1 = store
- ls_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = double
- ls_addr_i  in  ADDR_W  access address
- ls_wdata_i  in  DATA_W  store data
- ls_rdy_o  out  1  load/store request accepted this cycle (combinational)
- ls_done_o  out  1  one-cycle load/store completion pulse
- ls_rdata_o  out  DATA_W  load data, valid with ls_done_o
- ls_err_o  out  1  misaligned access or timeout, valid with ls_done_o
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  memory write enable
- mem_size_o  out  2  memory access size, same encoding as ls_size_i
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory acknowledge; read data valid in the same cycle
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE; every output and register cleared to 0 (all mem_*, done/err/rdata outputs, streak and timeout counters).
- Reset mid-transfer aborts the transfer: no done pulse, mem_req_o drops immediately.
- FSM states are IDLE, BUSY_IF and BUSY_LS.
- Acceptance happens only in IDLE. Handshake is req & rdy.
- Grant in IDLE:
  - LS has priority by default.
  - IF wins if ls_req_i = 0, or if (if_req_i = 1 and ls_streak == MAX_LS_STREAK).
- ls_streak:
  - +1 on each LS grant taken while if_req_i = 1, saturating.
  - Cleared on an IF grant, and on any IDLE cycle with if_req_i = 0.
- On accept, latch we, size, addr and wdata into mem_* registers (IF: we = 0, size = 10). State moves to BUSY_x next cycle, mem_req_o = 1 from that cycle on.
- Alignment check for LS, done at accept:
  - Misaligned means (size = 01 and addr[0] ≠ 0), (size = 10 and addr[1:0] ≠ 0), or (size = 11 and addr[2:0] ≠ 0).
  - A misaligned LS request is accepted but issues no memory request. Next cycle: ls_done_o = 1, ls_err_o = 1, ls_rdata_o = 0; state stays IDLE.
- IF alignment: if_addr_i[1:0] ≠ 0 gives the same error path on the if_* outputs.
- In BUSY_x, mem_* outputs are stable until ack.
- On mem_ack_i = 1:
  - Next cycle: x_done_o = 1, x_rdata_o = mem_rdata_i registered (0 for stores), x_err_o = 0.
  - mem_req_o = 0; state = IDLE.
  - Minimum latency is accept → done in 3 cycles when ack arrives in the first BUSY cycle.
- The done cycle is an IDLE cycle, so a new request can be accepted in it.
- Timeout:
  - The counter increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT: drop mem_req_o, pulse x_done_o with x_err_o = 1 and rdata = 0, return to IDLE.
  - If ack and expiry occur in the same cycle, ack wins.
- mem_ack_i while IDLE is ignored.
- done/err/rdata outputs are held for exactly one cycle, then rdata clears to 0.

Test Plan:
- IF only: if_addr = 0x8000_0000, ack 2 cycles after mem_req_o rises, rdata = 0x00000413 → if_done_o pulses once, if_rdata_o = 0x413, mem_we_o = 0, mem_size_o = 10.
- Simultaneous req: IF and LS store (addr 0x8000_1008, size 11, wdata 0xDEADBEEF) in the same cycle → ls_rdy_o = 1 and if_rdy_o = 0; memory sees the store first, then the fetch after ls_done_o.
- Starvation guard: ls_req_i held high with IF pending and MAX_LS_STREAK = 4 → exactly 4 LS grants, then 1 IF grant, then LS resumes.
- Misaligned: LS load size 10 at addr 0x8000_0002 → no mem_req_o; ls_done_o = 1 and ls_err_o = 1 the next cycle.
- Timeout: mem_ack_i never asserted, TIMEOUT = 255 → mem_req_o drops and ls_err_o pulses after 255 BUSY cycles. A second run with ack in the expiry cycle → ls_err_o = 0.
- Reset mid-op: rst low during BUSY_LS → mem_req_o = 0 immediately, no done pulse; after release the FSM is in IDLE and the next request completes normally.
